// File: rtl/sqrt2_host.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt2_host
//  Purpose  : Host-side sequencer for one sqrt2 core. Takes a half-precision
//             operand on a valid/ready channel, loads it onto the shared
//             tri-state IO_DATA bus, pulses ENABLE, waits for RESULT (with a
//             timeout guard), and returns the captured result and class flags
//             on a valid/ready channel.
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt2_host #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  // operand channel
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_DATA,
  // result channel
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_DATA,
  output logic        OUT_NAN,
  output logic        OUT_PINF,
  output logic        OUT_NINF,
  output logic        OUT_TIMEOUT,
  // core side
  inout  wire  [15:0] IO_DATA,
  output logic        ENABLE,
  input  logic        RESULT,
  input  logic        IS_NAN,
  input  logic        IS_PINF,
  input  logic        IS_NINF
);

  // --------------------------------------------------------------------------
  // State encoding and constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_setup  = 3'd1;
  localparam logic [2:0] c_st_launch = 3'd2;
  localparam logic [2:0] c_st_wait   = 3'd3;
  localparam logic [2:0] c_st_resp   = 3'd4;

  // Last WAIT count value before the timeout fires; the counter is 16 bits so
  // any legal TIMEOUT_CYCLES (2..65535) fits without wrapping.
  localparam logic [15:0] c_last_cnt     = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] c_cnt_max      = 16'hFFFF;
  // Quiet NaN returned when the core never answers.
  localparam logic [15:0] c_timeout_data = 16'hFE00;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [2:0]  w_next_state;

  logic [15:0] r_operand;
  logic [15:0] r_wait_cnt;

  logic [15:0] r_out_data;
  logic        r_out_nan;
  logic        r_out_pinf;
  logic        r_out_ninf;
  logic        r_out_timeout;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_enable;
  logic        w_bus_drive;

  logic        w_accept;
  logic        w_timeout_hit;

  assign w_accept      = (r_state == c_st_idle) && IN_VALID;
  assign w_timeout_hit = (r_wait_cnt == c_last_cnt);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // Asynchronous reset returns to IDLE so ENABLE and the bus drop immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // RESULT takes priority over the timeout on the final count cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (IN_VALID) begin
          w_next_state = c_st_setup;
        end
      end
      c_st_setup: begin
        w_next_state = c_st_launch;
      end
      c_st_launch: begin
        w_next_state = c_st_wait;
      end
      c_st_wait: begin
        if (RESULT || w_timeout_hit) begin
          w_next_state = c_st_resp;
        end
      end
      c_st_resp: begin
        if (OUT_READY) begin
          w_next_state = c_st_idle;
        end
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (state only, no input-to-output paths)
  // --------------------------------------------------------------------------
  // Bus is driven only in SETUP/LAUNCH; the core owns it from the first WAIT
  // cycle. ENABLE stays low through RESP and SETUP so the core can re-arm.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_enable    = 1'b0;
    w_bus_drive = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_in_ready = 1'b1;
      end
      c_st_setup: begin
        w_bus_drive = 1'b1;
      end
      c_st_launch: begin
        w_bus_drive = 1'b1;
        w_enable    = 1'b1;
      end
      c_st_wait: begin
        w_enable = 1'b1;
      end
      c_st_resp: begin
        w_out_valid = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand register
  // --------------------------------------------------------------------------
  // Latched once at acceptance; later IN_DATA changes are ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_operand <= 16'h0000;
    end else if (w_accept) begin
      r_operand <= IN_DATA;
    end
  end

  // --------------------------------------------------------------------------
  // WAIT cycle counter
  // --------------------------------------------------------------------------
  // Cleared in LAUNCH so WAIT starts from zero; saturates rather than wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wait_cnt <= 16'h0000;
    end else if (r_state == c_st_launch) begin
      r_wait_cnt <= 16'h0000;
    end else if ((r_state == c_st_wait) && (r_wait_cnt != c_cnt_max)) begin
      r_wait_cnt <= r_wait_cnt + 16'h0001;
    end
  end

  // --------------------------------------------------------------------------
  // Result capture
  // --------------------------------------------------------------------------
  // Loaded only on the WAIT->RESP transition, so outputs hold until the
  // downstream handshake and core activity outside WAIT is ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_data    <= 16'h0000;
      r_out_nan     <= 1'b0;
      r_out_pinf    <= 1'b0;
      r_out_ninf    <= 1'b0;
      r_out_timeout <= 1'b0;
    end else if (r_state == c_st_wait) begin
      if (RESULT) begin
        r_out_data    <= IO_DATA;
        r_out_nan     <= IS_NAN;
        r_out_pinf    <= IS_PINF;
        r_out_ninf    <= IS_NINF;
        r_out_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_out_data    <= c_timeout_data;
        r_out_nan     <= 1'b1;
        r_out_pinf    <= 1'b0;
        r_out_ninf    <= 1'b0;
        r_out_timeout <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Port assignments
  // --------------------------------------------------------------------------
  assign IO_DATA     = w_bus_drive ? r_operand : 16'bz;
  assign ENABLE      = w_enable;
  assign IN_READY    = w_in_ready;
  assign OUT_VALID   = w_out_valid;
  assign OUT_DATA    = r_out_data;
  assign OUT_NAN     = r_out_nan;
  assign OUT_PINF    = r_out_pinf;
  assign OUT_NINF    = r_out_ninf;
  assign OUT_TIMEOUT = r_out_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sqrt2_host.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt2_host
//  Purpose  : Scoreboard bench for sqrt2_host with a behavioural sqrt2 core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt2_host;

  localparam int TMO = 8;

  typedef struct packed {
    logic [15:0] data;
    logic        nan;
    logic        pinf;
    logic        ninf;
    logic        tmo;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] IN_DATA = 16'h0000;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [15:0] OUT_DATA;
  logic        OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT;
  wire  [15:0] IO_DATA;
  logic        ENABLE;
  logic        RESULT;
  logic        IS_NAN, IS_PINF, IS_NINF;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_acc  = 0;
  int t_valid = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  sqrt2_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_NAN(OUT_NAN), .OUT_PINF(OUT_PINF), .OUT_NINF(OUT_NINF),
    .OUT_TIMEOUT(OUT_TIMEOUT),
    .IO_DATA(IO_DATA), .ENABLE(ENABLE), .RESULT(RESULT),
    .IS_NAN(IS_NAN), .IS_PINF(IS_PINF), .IS_NINF(IS_NINF)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- behavioural sqrt2 core ----------------
  // Hand-computed half-precision square roots: {result, nan, pinf, ninf}
  function automatic logic [18:0] sqrt_lut(input logic [15:0] x);
    case (x)
      16'h4800: return {16'h41A8, 3'b000};   // sqrt(8)  = 2.828
      16'h4000: return {16'h3DA8, 3'b000};   // sqrt(2)  = 1.414
      16'h3C00: return {16'h3C00, 3'b000};   // sqrt(1)  = 1
      16'h7C00: return {16'h7C00, 3'b010};   // sqrt(+inf)
      16'hBC00: return {16'hFE00, 3'b100};   // sqrt(-1) = NaN
      default:  return {16'h0000, 3'b000};
    endcase
  endfunction

  logic [15:0] m_op = 16'h0000;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 5;
  bit          m_silent = 1'b0;
  logic        m_drv;
  logic [18:0] m_res;

  always @(posedge CLK) begin
    if (!ENABLE) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else if (!m_busy && !m_done) begin
      m_busy <= 1'b1; m_op <= IO_DATA; m_cnt <= 0;
    end else if (m_busy && !m_silent) begin
      if (m_cnt == m_lat - 1) begin
        m_done <= 1'b1; m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign m_drv   = m_done && ENABLE;
  assign m_res   = sqrt_lut(m_op);
  assign IO_DATA = m_drv ? m_res[18:3] : 16'bz;
  assign RESULT  = m_drv;
  assign IS_NAN  = m_drv && m_res[2];
  assign IS_PINF = m_drv && m_res[1];
  assign IS_NINF = m_drv && m_res[0];

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (OUT_VALID && !prev_valid) t_valid = cyc;
    prev_valid = OUT_VALID;
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", {16'h0, OUT_DATA}, {16'h0, mon_e.data});
        chk("out_flags", {28'h0, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT},
            {28'h0, mon_e.nan, mon_e.pinf, mon_e.ninf, mon_e.tmo});
        chk("enable_low_in_resp", {31'h0, ENABLE}, 32'd0);
      end
    end
  end

  // ---------------- bus / enable observers ----------------
  logic [15:0] watch_op = 16'h4800;
  int drv_cnt = 0;
  int drv_en1 = 0;
  int low_run = 0;
  int last_gap = 0;

  always @(negedge CLK) begin
    if (!m_drv && IO_DATA == watch_op) begin
      drv_cnt++;
      if (ENABLE) drv_en1++;
    end
    if (!ENABLE) begin
      low_run++;
    end else begin
      if (low_run != 0) last_gap = low_run;
      low_run = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] d, input exp_t e, input bit push);
    int guard;
    guard = 0;
    if (push) exp_q.push_back(e);
    IN_DATA  = d;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && guard < 300) begin
      @(negedge CLK);
      guard++;
    end
    if (!IN_READY) chk("accept_wait_expired", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    t_acc    = cyc;
    IN_VALID = 1'b0;
    IN_DATA  = 16'hDEAD;
  endtask

  task automatic wait_out();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("output_wait_expired", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int guard;

    // Reset state
    #12;
    chk("rst_in_ready", {31'h0, IN_READY}, 32'd1);
    chk("rst_out_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("rst_out_data", {16'h0, OUT_DATA}, 32'd0);
    chk("rst_flags", {28'h0, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT}, 32'd0);
    chk("rst_enable", {31'h0, ENABLE}, 32'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // 1: sqrt(8), bus driven exactly SETUP+LAUNCH with ENABLE only in LAUNCH
    watch_op = 16'h4800;
    drv_cnt  = 0;
    drv_en1  = 0;
    send(16'h4800, '{16'h41A8, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_out();
    chk("latency_8800", t_valid - t_acc, 32'd8);
    chk("bus_drive_cycles", drv_cnt, 32'd2);
    chk("bus_drive_with_enable", drv_en1, 32'd1);

    // 2: back to back, NaN then +inf
    send(16'hBC00, '{16'hFE00, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b1);
    send(16'h7C00, '{16'h7C00, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1);
    wait_out();
    chk("enable_gap_ge2", {31'h0, (last_gap >= 2)}, 32'd1);

    // 3: core never answers -> timeout after TMO WAIT edges
    m_silent = 1'b1;
    send(16'h4800, '{16'hFE00, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b1);
    wait_out();
    chk("timeout_latency", t_valid - t_acc, 32'd2 + TMO);
    m_silent = 1'b0;

    // 4: RESULT on the final count cycle wins; one cycle later times out
    m_lat = 7;
    send(16'h3C00, '{16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_out();
    chk("final_cycle_latency", t_valid - t_acc, 32'd10);
    m_lat = 8;
    send(16'h3C00, '{16'hFE00, 1'b1, 1'b0, 1'b0, 1'b1}, 1'b1);
    wait_out();
    chk("late_result_latency", t_valid - t_acc, 32'd10);
    m_lat = 5;

    // 5: backpressure holds the result; pending operand waits for handshake
    OUT_READY = 1'b0;
    send(16'h3C00, '{16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    exp_q.push_back('{16'h41A8, 1'b0, 1'b0, 1'b0, 1'b0});
    IN_VALID = 1'b1;
    IN_DATA  = 16'h4800;
    guard = 0;
    while (!OUT_VALID && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    chk("hold_out_valid_seen", {31'h0, OUT_VALID}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("hold_out_data", {16'h0, OUT_DATA}, 32'h3C00);
      chk("hold_in_ready", {31'h0, IN_READY}, 32'd0);
      chk("hold_out_valid", {31'h0, OUT_VALID}, 32'd1);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("idle_after_handshake", {31'h0, IN_READY}, 32'd1);
    chk("valid_drop_after_handshake", {31'h0, OUT_VALID}, 32'd0);
    @(posedge CLK);
    #1;
    chk("pending_accepted", {31'h0, IN_READY}, 32'd0);
    t_acc    = cyc;
    IN_VALID = 1'b0;
    IN_DATA  = 16'hDEAD;
    wait_out();
    chk("pending_latency", t_valid - t_acc, 32'd8);

    // 6: asynchronous reset mid-WAIT, then a fresh operation
    send(16'h4800, '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    chk("pre_reset_enable", {31'h0, ENABLE}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("async_enable", {31'h0, ENABLE}, 32'd0);
    chk("async_bus_released", {31'h0, (IO_DATA == 16'h4800)}, 32'd0);
    chk("async_in_ready", {31'h0, IN_READY}, 32'd1);
    chk("async_out_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("async_out_data", {16'h0, OUT_DATA}, 32'd0);
    chk("async_flags", {28'h0, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT}, 32'd0);
    #20;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    send(16'h4000, '{16'h3DA8, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_out();
    chk("post_reset_latency", t_valid - t_acc, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
